// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pcsource encodings and fetch constants for the prefetching IF stage
package pipe_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_REG = 2'b10,
    PCSRC_JMP = 2'b11
  } pcsrc_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_INC           = 4;

endpackage

// File: rtl/pipeif_prefetch_if.sv
// rtl/pipeif_prefetch_if.sv - instruction ROM bus and IF->ID handshake bundle
interface pipeif_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROM_AW = 8
);
  logic [ROM_AW-1:0] imem_addr;
  logic              imem_req;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] ins;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc4;
  logic              ins_valid;
  logic              id_ready;

  modport master (
    output imem_addr, imem_req, ins, pc, pc4, ins_valid,
    input  imem_rdata, id_ready
  );

  modport slave (
    input  imem_addr, imem_req, ins, pc, pc4, ins_valid,
    output imem_rdata, id_ready
  );
endinterface

// File: rtl/pipe_sync_fifo.sv
// rtl/pipe_sync_fifo.sv - synchronous show-ahead FIFO with clear and occupancy count
module pipe_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    // Clear wins over a same-cycle push or pop.
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_q];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign count     = cnt_q;

  overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !clr && full));
  underflow_a: assert property (@(posedge clk) disable iff (rst)
    !(pop && !clr && empty));

endmodule

// File: rtl/pipeif_prefetch.sv
// rtl/pipeif_prefetch.sv - IF stage with fetch PC, 1-cycle ROM interface and DEPTH-entry prefetch queue
// Define PREFETCH_BYPASS_EN to let a response reach ID directly when the queue is empty.
module pipeif_prefetch
  import pipe_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                ROM_AW   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        pcsource,
  input  logic [ADDR_W-1:0] bpc,
  input  logic [ADDR_W-1:0] da,
  input  logic [ADDR_W-1:0] jpc,
  pipeif_prefetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] fpc_q, fpc_d, ipc_q, ipc_d, target;
  logic              inflight_q, inflight_d, kill_q, kill_d;
  logic              redirect, issue, resp_ok, ins_valid, pop;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit;
  logic [EW-1:0]     fifo_head, head;
  logic [ADDR_W-1:0] head_pc;

  always_comb begin
    redirect = (pcsource != PCSRC_SEQ);
    target   = fpc_q;
    case (pcsrc_e'(pcsource))
      PCSRC_BR:  target = bpc;
      PCSRC_REG: target = da;
      PCSRC_JMP: target = jpc;
      default:   target = fpc_q;
    endcase

    // Credit ignores a same-cycle pop, so a full queue never sees an extra push.
    credit  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    issue   = !reset && !redirect && (credit < (CW+1)'(DEPTH));
    resp_ok = !reset && inflight_q && !kill_q && !redirect;

    fpc_d = fpc_q;
    if (redirect) begin
      fpc_d = target & ~ADDR_W'(3);
    end else if (issue) begin
      fpc_d = fpc_q + ADDR_W'(PC_INC);
    end
    inflight_d = issue;
    kill_d     = redirect && inflight_q;
    ipc_d      = issue ? fpc_q : ipc_q;

`ifdef PREFETCH_BYPASS_EN
    ins_valid = !reset && (!fifo_empty || resp_ok);
    head      = fifo_empty ? {ipc_q, bus.imem_rdata} : fifo_head;
    fifo_push = resp_ok && !(fifo_empty && bus.id_ready);
`else
    ins_valid = !reset && !fifo_empty;
    head      = fifo_head;
    fifo_push = resp_ok;
`endif
    pop      = ins_valid && bus.id_ready && !redirect;
    fifo_pop = pop && !fifo_empty;

    head_pc        = head[EW-1:DATA_W];
    bus.imem_addr  = fpc_q[ROM_AW+1:2];
    bus.imem_req   = issue;
    bus.ins_valid  = ins_valid;
    bus.ins        = ins_valid ? head[DATA_W-1:0] : '0;
    bus.pc         = ins_valid ? head_pc : '0;
    bus.pc4        = ins_valid ? head_pc + ADDR_W'(PC_INC) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fpc_q      <= RESET_PC;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      ipc_q      <= ipc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  pipe_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst       (reset),
    .clr       (redirect),
    .push      (fifo_push),
    .push_data ({ipc_q, bus.imem_rdata}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: doc/pipeif_prefetch.md
Name: pipeif_prefetch

Overview:
- Parametrised successor to the single-cycle IF stage.
- Owns the fetch PC and drives a synchronous, 1-cycle-latency instruction ROM.
- Buffers fetched instructions in a DEPTH-entry prefetch queue and hands them to ID over a valid/ready handshake.
- Branch, register and jump redirects arrive on the existing pcsource encoding; a redirect flushes the queue and kills the in-flight fetch.

Parameters:
- ADDR_W, 32, width of PC and redirect targets.
- DATA_W, 32, instruction width.
- ROM_AW, 8, ROM word-address width; imem_addr = fpc[ROM_AW+1:2].
- DEPTH, 4, prefetch queue entries (power of 2, >=2).
- RESET_PC, 0, fetch PC after reset.

Ports:
- clock, in, 1: single clock; also used as the ROM clock.
- reset, in, 1: synchronous, active-high.
- pcsource, in, 2: 00 sequential, 01 bpc, 10 da, 11 jpc; any non-zero value is a redirect this cycle.
- bpc, in, ADDR_W: branch target.
- da, in, ADDR_W: register (jr) target.
- jpc, in, ADDR_W: jump target.
- imem_addr, out, ROM_AW: ROM word address.
- imem_req, out, 1: fetch issued this cycle.
- imem_rdata, in, DATA_W: ROM data, valid the cycle after imem_req.
- ins, out, DATA_W: head instruction.
- pc, out, ADDR_W: address of ins.
- pc4, out, ADDR_W: pc+4.
- ins_valid, out, 1: head entry valid.
- id_ready, in, 1: ID accepts the head this cycle.

Behaviour:
- Reset:
  - fpc=RESET_PC; queue empty; inflight=0; kill=0.
  - ins_valid=0, imem_req=0; ins, pc and pc4 read 0.
  - Reset overrides a simultaneous redirect.
- Issue: imem_req=1 when !reset, no redirect this cycle, and count+inflight<DEPTH. The credit check is conservative: a pop in the same cycle is not counted.
  - On issue: fpc<=fpc+4, inflight<=1, issued PC is captured.
  - Otherwise inflight<=0.
- Response: in the cycle after an issue, push {imem_rdata, issued PC} unless kill=1.
- Pop: occurs when ins_valid && id_ready. ins, pc and pc4 come from the head, registered show-ahead. Simultaneous push and pop is legal at any count, including full. Overflow is impossible by credit and must be asserted.
- Redirect at cycle T (pcsource!=00):
  - fpc<=target with bits [1:0] forced 0.
  - Queue cleared; any pop in cycle T is ignored.
  - kill<=inflight.
  - No issue in T. Target issued at T+1, pushed at edge of T+2, ins_valid=1 in T+3.
  - Back-to-back redirects: the last one wins, and each kills the older in-flight fetch.
- Wrap: fpc wraps modulo 2^ADDR_W. ROM index aliases modulo 2^ROM_AW words.
- Stall: with id_ready=0, the head and all outputs are held. Fetch continues until the queue is full, then imem_req=0.
- Steady state with id_ready=1: one instruction per cycle.

Optional Feature:
- PREFETCH_BYPASS_EN defined:
  - When the queue is empty and a non-killed response arrives, the response drives ins, pc and pc4 combinationally with ins_valid=1.
  - If id_ready=1 it is consumed without being pushed. Redirect-to-valid latency becomes T+2.
- Not defined: all instructions pass through the queue (T+3 latency).
- Credit rule is unchanged in both cases.

Decomposition:
- Shared package pipe_pkg:
  - PCSRC_SEQ/BR/REG/JMP encodings.
  - Default RESET_PC.
  - PC increment constant 4.
- One sub-module pipe_sync_fifo (parametrised width/depth, clear input, count output). Entry = {pc, ins}.

Test Plan:
- Reset then id_ready=1, ROM[i]=0x1000_0000+i -> imem_addr 0,1,2…; ins_valid first in cycle 2 after reset release (ins=0x1000_0000, pc=0, pc4=4); then one instruction per cycle.
- id_ready=0 for 10 cycles, DEPTH=4 -> imem_req deasserts once 4 are queued or in flight; head held at pc=0; after release, pc 0,4,8,12 pop in order with no gaps or duplicates.
- pcsource=01, bpc=0x40 at T while a fetch of 0x10 is in flight -> 0x10 never appears; imem_addr=0x10 at T+1; ins_valid with pc=0x40 at T+3.
- pcsource=11 at T, then 10 at T+1 with da=0x80 -> the jpc stream is discarded; the first valid pc is 0x80.
- Redirect da=0x7E (misaligned) -> pc=0x7C; fpc=0xFFFF_FFFC fetches then wraps to 0.
- With PREFETCH_BYPASS_EN: the redirect case gives ins_valid at T+2; reset asserted mid-stream -> ins_valid=0 and imem_req=0 next cycle, restarting at RESET_PC.
